// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx
// ----------------
// Source-domain half of a 4-phase request/acknowledge clock-domain crossing.
// A word offered on SRC_DATA/SRC_VALID is captured into TX_DATA. TX_REQ is then
// raised toward the destination domain. The asynchronous RX_ACK comes back
// through a NUM_STAGES flop synchronizer. The request is dropped once the
// synchronized ack reads high. The transfer completes, with a one-cycle DONE
// pulse, once the synchronized ack reads low again.
//
// Parameters
//   BUS_WIDTH   width of the transferred data word
//   NUM_STAGES  depth of the RX_ACK synchronizer (minimum 2)
//
// Ports
//   CLK        in   source-domain clock, rising edge
//   RST        in   synchronous active-high reset
//   SRC_DATA   in   word offered by the local source
//   SRC_VALID  in   SRC_DATA is valid
//   SRC_READY  out  a word can be accepted this cycle (combinational)
//   TX_DATA    out  registered word held stable for the destination domain
//   TX_REQ     out  registered 4-phase request
//   RX_ACK     in   asynchronous acknowledge from the destination domain
//   BUSY       out  registered, high while a transfer is in progress
//   DONE       out  registered one-cycle pulse when a transfer completes

module cdc_handshake_tx #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] SRC_DATA,
  input  logic                 SRC_VALID,
  output logic                 SRC_READY,
  output logic [BUS_WIDTH-1:0] TX_DATA,
  output logic                 TX_REQ,
  input  logic                 RX_ACK,
  output logic                 BUSY,
  output logic                 DONE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_t;

  state_t                state;
  logic [NUM_STAGES-1:0] ack_sync;
  logic                  ack_s;

  // Synchronizer for the acknowledge coming from the other clock domain.
  // RX_ACK is used nowhere else. Only the last stage, ack_s, feeds the FSM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[NUM_STAGES-2:0], RX_ACK};
    end
  end

  assign ack_s = ack_sync[NUM_STAGES-1];

  // A new word is accepted only when idle and the destination has released
  // its acknowledge. This blocks a stale ack from starting a bogus transfer.
  assign SRC_READY = (state == IDLE) && !ack_s && !RST;

  // Handshake sequencer. Every output is a flop, so TX_REQ cannot glitch.
  // TX_DATA is written only on accept. It therefore holds for the whole
  // transfer, whatever SRC_DATA does meanwhile. Reset aborts any transfer
  // in flight and discards the word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      TX_DATA <= '0;
      TX_REQ  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (SRC_VALID && SRC_READY) begin
            TX_DATA <= SRC_DATA;
            TX_REQ  <= 1'b1;
            BUSY    <= 1'b1;
            state   <= REQ_HI;
          end
        end
        REQ_HI: begin
          // Wait as long as needed. There is deliberately no timeout.
          if (ack_s) begin
            TX_REQ <= 1'b0;
            state  <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          TX_REQ <= 1'b0;
          BUSY   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx
// -------------------
// Directed bench for cdc_handshake_tx with BUS_WIDTH=8 and NUM_STAGES=2.
// The scenarios run in order: reset, single transfer, back-to-back
// transfers, stale ack, reset mid-transfer and ack glitch.

module tb_cdc_handshake_tx;

  localparam int BW = 8;
  localparam int NS = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic [BW-1:0] SRC_DATA;
  logic          SRC_VALID;
  logic          SRC_READY;
  logic [BW-1:0] TX_DATA;
  logic          TX_REQ;
  logic          RX_ACK;
  logic          BUSY;
  logic          DONE;

  int passCount  = 0;
  int checkCount = 0;
  int doneSeen   = 0;

  cdc_handshake_tx #(
    .BUS_WIDTH (BW),
    .NUM_STAGES(NS)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .SRC_DATA (SRC_DATA),
    .SRC_VALID(SRC_VALID),
    .SRC_READY(SRC_READY),
    .TX_DATA  (TX_DATA),
    .TX_REQ   (TX_REQ),
    .RX_ACK   (RX_ACK),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  // 10-unit source clock.
  always #5 CLK = ~CLK;

  // Drives all inputs at once. Callers use this just after a clock edge.
  task automatic applyStimulus(input logic rst, input logic valid,
                               input logic [BW-1:0] data, input logic ack);
    RST       = rst;
    SRC_VALID = valid;
    SRC_DATA  = data;
    RX_ACK    = ack;
  endtask

  // Advances one rising edge and settles 1 unit past it. This also counts
  // DONE pulses, which lets a scenario check its number of completions.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (DONE === 1'b1) doneSeen++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  initial begin
    // Reset state. A valid word offered during reset must be ignored.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    tick(); tick(); tick();
    checkOutput("rst_tx_req", 32'(TX_REQ), 0);
    checkOutput("rst_busy", 32'(BUSY), 0);
    checkOutput("rst_done", 32'(DONE), 0);
    checkOutput("rst_tx_data", 32'(TX_DATA), 0);
    checkOutput("rst_ready", 32'(SRC_READY), 0);
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);
    tick();
    checkOutput("rst_override_req", 32'(TX_REQ), 0);
    checkOutput("rst_override_data", 32'(TX_DATA), 0);
    checkOutput("rst_override_ready", 32'(SRC_READY), 0);

    // Single transfer of 0xA5. The accept happens at edge 0. RX_ACK is high
    // for edges 3..7, so the rise is sampled at edge 3 and the fall at
    // edge 8. Expect TX_REQ low after edge 5, and DONE with BUSY low after
    // edge 10. SRC_DATA changes every cycle while busy.
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0);
    #1;
    checkOutput("t1_ready_idle", 32'(SRC_READY), 1);
    tick();
    checkOutput("t1_accept_req", 32'(TX_REQ), 1);
    checkOutput("t1_accept_busy", 32'(BUSY), 1);
    checkOutput("t1_accept_data", 32'(TX_DATA), 'hA5);
    checkOutput("t1_ready_busy", 32'(SRC_READY), 0);
    doneSeen = 0;
    for (int k = 1; k <= 11; k++) begin
      applyStimulus(1'b0, (k <= 10), 8'(k * 37), (k >= 3 && k <= 7));
      tick();
      checkOutput($sformatf("t1_data_k%0d", k), 32'(TX_DATA), 'hA5);
      checkOutput($sformatf("t1_req_k%0d", k), 32'(TX_REQ), 32'(k <= 4));
      checkOutput($sformatf("t1_busy_k%0d", k), 32'(BUSY), 32'(k <= 9));
      checkOutput($sformatf("t1_done_k%0d", k), 32'(DONE), 32'(k == 10));
    end
    checkOutput("t1_done_count", 32'(doneSeen), 1);

    // Back-to-back transfers. SRC_VALID stays high while words 1, 2 and 3
    // are offered, and the responder echoes TX_REQ one cycle later. Accepts
    // land 7 edges apart, at k=0, 7 and 14. DONE comes 6 edges after each
    // accept, when SRC_READY is already high again.
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0);
    tick();
    checkOutput("t2_accept1_data", 32'(TX_DATA), 1);
    checkOutput("t2_accept1_req", 32'(TX_REQ), 1);
    doneSeen = 0;
    for (int k = 1; k <= 21; k++) begin
      applyStimulus(1'b0, (k <= 14), ((k <= 7) ? 8'h02 : 8'h03), TX_REQ);
      tick();
      checkOutput($sformatf("t2_req_k%0d", k), 32'(TX_REQ),
                  32'((k % 7) <= 2 && k < 21));
      checkOutput($sformatf("t2_done_k%0d", k), 32'(DONE), 32'((k % 7) == 6));
      checkOutput($sformatf("t2_busy_k%0d", k), 32'(BUSY),
                  32'((k % 7) != 6 && k < 21));
      checkOutput($sformatf("t2_data_k%0d", k), 32'(TX_DATA),
                  (k < 7) ? 1 : ((k < 14) ? 2 : 3));
      if ((k % 7) == 6)
        checkOutput($sformatf("t2_ready_on_done_k%0d", k), 32'(SRC_READY), 1);
    end
    checkOutput("t2_done_count", 32'(doneSeen), 3);

    // Stale ack. RX_ACK is high through reset release. Once it is
    // synchronized, acceptance is blocked until 2 edges after it falls.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    tick(); tick();
    checkOutput("t3_ready_in_reset", 32'(SRC_READY), 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    tick(); tick();
    checkOutput("t3_ready_stale", 32'(SRC_READY), 0);
    applyStimulus(1'b0, 1'b1, 8'h77, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("t3_blocked_req_%0d", k), 32'(TX_REQ), 0);
      checkOutput($sformatf("t3_blocked_ready_%0d", k), 32'(SRC_READY), 0);
    end
    applyStimulus(1'b0, 1'b1, 8'h77, 1'b0);
    tick();
    checkOutput("t3_fall1_ready", 32'(SRC_READY), 0);
    checkOutput("t3_fall1_req", 32'(TX_REQ), 0);
    tick();
    checkOutput("t3_fall2_ready", 32'(SRC_READY), 1);
    checkOutput("t3_fall2_req", 32'(TX_REQ), 0);
    tick();
    checkOutput("t3_accept_req", 32'(TX_REQ), 1);
    checkOutput("t3_accept_data", 32'(TX_DATA), 'h77);

    // Reset for one cycle while in REQ_HI, with a simultaneous valid word.
    // The transfer is aborted and the next accept proceeds normally.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("t4_still_req", 32'(TX_REQ), 1);
    doneSeen = 0;
    applyStimulus(1'b1, 1'b1, 8'hC3, 1'b0);
    tick();
    checkOutput("t4_abort_req", 32'(TX_REQ), 0);
    checkOutput("t4_abort_busy", 32'(BUSY), 0);
    checkOutput("t4_abort_data", 32'(TX_DATA), 0);
    checkOutput("t4_abort_done", 32'(DONE), 0);
    applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0);
    #1;
    checkOutput("t4_ready_after", 32'(SRC_READY), 1);
    tick();
    checkOutput("t4_accept_req", 32'(TX_REQ), 1);
    checkOutput("t4_accept_data", 32'(TX_DATA), 'h5A);

    // Ack glitch. RX_ACK is a one-cycle pulse while in REQ_HI, and
    // SRC_VALID stays high with other data. The pulse propagates once, so
    // the FSM goes through REQ_LO and finishes with exactly one DONE.
    applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1);
    tick();
    checkOutput("t5_g1_req", 32'(TX_REQ), 1);
    applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0);
    tick();
    checkOutput("t5_g2_req", 32'(TX_REQ), 1);
    tick();
    checkOutput("t5_g3_req", 32'(TX_REQ), 0);
    checkOutput("t5_g3_busy", 32'(BUSY), 1);
    checkOutput("t5_g3_data", 32'(TX_DATA), 'h5A);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("t5_g4_done", 32'(DONE), 1);
    checkOutput("t5_g4_busy", 32'(BUSY), 0);
    checkOutput("t5_g4_data", 32'(TX_DATA), 'h5A);
    tick();
    checkOutput("t5_g5_done", 32'(DONE), 0);
    checkOutput("t5_g5_req", 32'(TX_REQ), 0);
    checkOutput("t5_g5_ready", 32'(SRC_READY), 1);
    tick(); tick(); tick();
    checkOutput("t5_done_count", 32'(doneSeen), 1);
    checkOutput("t5_idle_busy", 32'(BUSY), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
